// File: rtl/effect_mode_controller.sv
// rtl/effect_mode_controller.sv - click-free sequencer for the effects datapath control code
//
// Turns raw board switch positions into the 4-bit control code of the audio
// effects datapath. Switch changes are synchronised, debounced, legalised
// (unknown codes become SILENT) and only applied on sample_req boundaries.
// A change between two non-silent effects is separated by a SILENT gap of
// MUTE_SAMPLES samples so the datapath never jumps between effects mid-signal.
//
// Ports:
//   clk          system clock, shared with the effects datapath
//   reset        asynchronous, active-high reset
//   sample_req   one-cycle pulse; the datapath consumes control in this cycle
//   mode_sel     raw switch code, asynchronous to clk
//   control      effect code driven to the datapath
//   busy         high while a mode change is pending or muting
//   change_done  one-cycle pulse in the first cycle control shows its final value

module effect_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MUTE_SAMPLES    = 64,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_req,
    input  logic [3:0] mode_sel,
    output logic [3:0] control,
    output logic       busy,
    output logic       change_done
);

    localparam logic [3:0] MODE_SILENT   = 4'b0000;
    localparam logic [3:0] MODE_SINE     = 4'b0001;
    localparam logic [3:0] MODE_FEEDBACK = 4'b0011;

    localparam logic [CNT_W-1:0] DCNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MCNT_MAX = CNT_W'(MUTE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ARM  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Two-flop synchroniser for the asynchronous switch code.
    logic [3:0] sync0;
    logic [3:0] sync1;

    // Debounce candidate, stability counter and the accepted target mode.
    logic [3:0]       mapped_sel;
    logic [3:0]       candidate;
    logic [CNT_W-1:0] dcnt;
    logic [3:0]       target_mode;

    // Sequencer state.
    state_t           state;
    logic [3:0]       active_mode;
    logic [CNT_W-1:0] mcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0 <= 4'b0000;
            sync1 <= 4'b0000;
        end else begin
            sync0 <= mode_sel;
            sync1 <= sync0;
        end
    end

    // Unknown switch codes are folded onto SILENT before debouncing so that a
    // wandering switch between two legal detents cannot reach the datapath.
    always_comb begin
        mapped_sel = MODE_SILENT;
        if ((sync1 == MODE_SINE) || (sync1 == MODE_FEEDBACK)) begin
            mapped_sel = sync1;
        end
    end

    // A new value restarts the count; once the count saturates the candidate
    // has been stable long enough and is promoted to target_mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate   <= MODE_SILENT;
            dcnt        <= '0;
            target_mode <= MODE_SILENT;
        end else begin
            if (mapped_sel != candidate) begin
                candidate <= mapped_sel;
                dcnt      <= '0;
            end else if (dcnt < DCNT_MAX) begin
                dcnt <= dcnt + CNT_ONE;
            end else if (target_mode != candidate) begin
                target_mode <= candidate;
            end
        end
    end

    // control only moves on a sample_req edge, so the datapath always consumes
    // the value that was already stable during the requesting cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            active_mode <= MODE_SILENT;
            mcnt        <= '0;
            control     <= MODE_SILENT;
            busy        <= 1'b0;
            change_done <= 1'b0;
        end else begin
            change_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (target_mode != active_mode) begin
                        state <= ST_ARM;
                        busy  <= 1'b1;
                    end
                end

                ST_ARM: begin
                    if (target_mode == active_mode) begin
                        // Switch went back before any sample was taken.
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end else if (sample_req) begin
                        if ((active_mode == MODE_SILENT) || (target_mode == MODE_SILENT)) begin
                            // Either side already silent: no gap needed.
                            control     <= target_mode;
                            active_mode <= target_mode;
                            change_done <= 1'b1;
                            state       <= ST_RUN;
                            busy        <= 1'b0;
                        end else begin
                            control <= MODE_SILENT;
                            mcnt    <= '0;
                            state   <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (sample_req) begin
                        // A move to SILENT ends the gap early; anything else
                        // (including a return to the old mode) waits out the gap
                        // and then takes whatever target is current.
                        if ((mcnt == MCNT_MAX) || (target_mode == MODE_SILENT)) begin
                            control     <= target_mode;
                            active_mode <= target_mode;
                            change_done <= 1'b1;
                            state       <= ST_RUN;
                            busy        <= 1'b0;
                        end else begin
                            mcnt <= mcnt + CNT_ONE;
                        end
                    end
                end

                default: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
